// File: rtl/dcache_write_buffer.sv
// Write-back buffer that queues evicted dirty DCache lines ahead of the AXI write channel.
// Optional macro WB_MERGE_EN: a push to a line already queued (and not in flight) overwrites it in place.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [ADDR_W-1:0]          push_addr_i,
    input  logic [LINE_W-1:0]          push_data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic [ADDR_W-1:0]          lookup_addr_i,
    output logic                       hit_o,
    output logic [LINE_W-1:0]          hit_data_o,
    output logic                       axi_wen_o,
    output logic [ADDR_W-1:0]          axi_awaddr_o,
    output logic [LINE_W-1:0]          axi_wdata_o,
    input  logic                       axi_bvalid_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [0:0]        state_q;

    logic [TAG_W-1:0]  push_tag;
    logic [TAG_W-1:0]  lookup_tag;
    logic              full;
    logic              pop;
    logic              append;
    logic              merge_hit;
    logic              merge_wr;
    logic [PTR_W-1:0]  merge_idx;
    logic [PTR_W-1:0]  lookup_idx;
    logic              unused_addr_bits;

    assign push_tag         = push_addr_i[ADDR_W-1:5];
    assign lookup_tag       = lookup_addr_i[ADDR_W-1:5];
    assign unused_addr_bits = ^{push_addr_i[4:0], lookup_addr_i[4:0]};

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = (state_q == SEND) && axi_bvalid_i;

`ifdef WB_MERGE_EN
    // The in-flight head is excluded so its burst data stays stable until bvalid.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == push_tag) &&
                !((state_q == SEND) && (PTR_W'(i) == head_q))) begin
                merge_hit = 1'b1;
                merge_idx = PTR_W'(i);
            end
        end
    end
`else
    assign merge_hit = 1'b0;
    assign merge_idx = '0;
`endif

    assign merge_wr = push_i && merge_hit;
    assign append   = push_i && !merge_hit && !full;

    always_ff @(posedge clk) begin
        if (append) begin
            tag_q[tail_q]  <= push_tag;
            data_q[tail_q] <= push_data_i;
        end else if (merge_wr) begin
            data_q[merge_idx] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            if (append) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(append) - CNT_W'(pop);
            case (state_q)
                IDLE:    if (count_q != '0) state_q <= SEND;
                SEND:    if (axi_bvalid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Walk from head to tail so a later match overrides an earlier one: youngest wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        lookup_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_idx = head_q + PTR_W'(i);
            if (valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[lookup_idx];
            end
        end
    end

    assign full_o       = full;
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign axi_wen_o    = (state_q == SEND) && !axi_bvalid_i;
    assign axi_awaddr_o = {tag_q[head_q], 5'b0};
    assign axi_wdata_o  = data_q[head_q];

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: drained lines are scored against a queue of accepted pushes.
module tb_dcache_write_buffer;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         push_i;
    logic [31:0]  push_addr_i;
    logic [255:0] push_data_i;
    logic         full_o;
    logic         empty_o;
    logic [2:0]   count_o;
    logic [31:0]  lookup_addr_i;
    logic         hit_o;
    logic [255:0] hit_data_o;
    logic         axi_wen_o;
    logic [31:0]  axi_awaddr_o;
    logic [255:0] axi_wdata_o;
    logic         axi_bvalid_i;

    entry_t sb[$];
    int     vectors = 0;
    int     miscompares = 0;

    dcache_write_buffer #(.DEPTH(4), .ADDR_W(32), .LINE_W(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_i),
        .push_addr_i  (push_addr_i),
        .push_data_i  (push_data_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .lookup_addr_i(lookup_addr_i),
        .hit_o        (hit_o),
        .hit_data_o   (hit_data_o),
        .axi_wen_o    (axi_wen_o),
        .axi_awaddr_o (axi_awaddr_o),
        .axi_wdata_o  (axi_wdata_o),
        .axi_bvalid_i (axi_bvalid_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one push cycle; accepted lines become expected drain traffic.
    task automatic applyStimulus(input logic [31:0] addr, input logic [255:0] data, input bit expAccept);
        push_i      = 1'b1;
        push_addr_i = addr;
        push_data_i = data;
        #1;
        checkOutput("push_full", full_o, !expAccept);
        @(posedge clk);
        #1;
        push_i = 1'b0;
        if (expAccept) sb.push_back('{addr & ~32'h1f, data});
    endtask

    task automatic waitSend();
        int n = 0;
        while (axi_wen_o !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("wen_rise", axi_wen_o, 1'b1);
    endtask

    task automatic drainOne();
        entry_t e;
        waitSend();
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            checkOutput("drain_addr", axi_awaddr_o, e.addr);
            checkOutput("drain_data", axi_wdata_o, e.data);
        end
        axi_bvalid_i = 1'b1;
        #1;
        checkOutput("wen_bvalid", axi_wen_o, 1'b0);
        @(posedge clk);
        #1;
        axi_bvalid_i = 1'b0;
    endtask

    task automatic runSingle();
        applyStimulus(32'h8000_0040, {224'h0, 32'h1111_1111}, 1'b1);
        checkOutput("single_count", count_o, 1);
        lookup_addr_i = 32'h8000_005f;
        #1;
        checkOutput("single_hit", hit_o, 1'b1);
        checkOutput("single_hit_data", hit_data_o, {224'h0, 32'h1111_1111});
        drainOne();
        checkOutput("single_empty", empty_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        entry_t e;
        logic [31:0] base;
        logic [255:0] oldData;
        rst_n         = 1'b0;
        push_i        = 1'b0;
        push_addr_i   = '0;
        push_data_i   = '0;
        lookup_addr_i = '0;
        axi_bvalid_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_full", full_o, 1'b0);
        checkOutput("rst_empty", empty_o, 1'b1);
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_wen", axi_wen_o, 1'b0);
        checkOutput("rst_hit", hit_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // bvalid while idle and empty must be ignored
        axi_bvalid_i = 1'b1;
        @(posedge clk);
        #1;
        axi_bvalid_i = 1'b0;
        checkOutput("idle_bvalid_count", count_o, 0);

        runSingle();

        // Fill with bvalid withheld, refuse a fifth line, drain in order
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h100 + 32'(i) * 32'h20, {8{32'h100 + 32'(i)}}, 1'b1);
        checkOutput("fill_full", full_o, 1'b1);
        checkOutput("fill_count", count_o, 4);
        lookup_addr_i = 32'h0000_0990;
        #1;
        checkOutput("miss_hit", hit_o, 1'b0);
        checkOutput("miss_data", hit_data_o, 256'h0);
        applyStimulus(32'h180, {8{32'hdead_beef}}, 1'b0);
        checkOutput("refused_count", count_o, 4);
        for (int i = 0; i < 4; i++) drainOne();
        checkOutput("fill_empty", empty_o, 1'b1);

        // Full buffer with simultaneous push and pop: push refused, retried next cycle
        for (int r = 0; r < 2; r++) begin
            base = 32'h400 + 32'(r) * 32'h100;
            for (int i = 0; i < 4; i++)
                applyStimulus(base + 32'(i) * 32'h20, {224'h0, base + 32'(i)}, 1'b1);
            waitSend();
            push_i       = 1'b1;
            push_addr_i  = base + 32'h80;
            push_data_i  = {224'h0, base + 32'h80};
            axi_bvalid_i = 1'b1;
            #1;
            checkOutput("pp_full", full_o, 1'b1);
            checkOutput("pp_wen", axi_wen_o, 1'b0);
            e = sb.pop_front();
            checkOutput("pp_addr", axi_awaddr_o, e.addr);
            @(posedge clk);
            #1;
            push_i       = 1'b0;
            axi_bvalid_i = 1'b0;
            checkOutput("pp_count", count_o, 3);
            applyStimulus(base + 32'h80, {224'h0, base + 32'h80}, 1'b1);
            checkOutput("retry_count", count_o, 4);
            for (int i = 0; i < 4; i++) drainOne();
            checkOutput("round_empty", empty_o, 1'b1);
        end

        // Same line as in-flight head always appends
        oldData = {8{32'h1234_5678}};
        applyStimulus(32'h200, oldData, 1'b1);
        waitSend();
        applyStimulus(32'h200, {8{32'hAAAA_AAAA}}, 1'b1);
        checkOutput("inflight_count", count_o, 2);
        lookup_addr_i = 32'h200;
        #1;
        checkOutput("inflight_hit_data", hit_data_o, {8{32'hAAAA_AAAA}});
        checkOutput("inflight_wdata", axi_wdata_o, oldData);
        drainOne();
        drainOne();

        // Push to a queued (not in-flight) line: merge or append depending on build
        applyStimulus(32'h300, {8{32'h3030_3030}}, 1'b1);
        waitSend();
        applyStimulus(32'h320, {8{32'h3232_3232}}, 1'b1);
        applyStimulus(32'h320, {8{32'h5555_5555}}, 1'b1);
`ifdef WB_MERGE_EN
        e = sb.pop_back();
        sb[1].data = e.data;
        checkOutput("merge_count", count_o, 2);
`else
        checkOutput("append_count", count_o, 3);
`endif
        lookup_addr_i = 32'h320;
        #1;
        checkOutput("dup_hit_data", hit_data_o, {8{32'h5555_5555}});
        while (sb.size() > 0) drainOne();
        checkOutput("dup_empty", empty_o, 1'b1);

        // Reset in the middle of a burst
        applyStimulus(32'h500, {8{32'h5050_5050}}, 1'b1);
        waitSend();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wen", axi_wen_o, 1'b0);
        checkOutput("midrst_empty", empty_o, 1'b1);
        checkOutput("midrst_count", count_o, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runSingle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Write-back buffer between the DCache eviction path and the cached-line write channel of the cache/AXI interface (`data_wen_i` / `data_awaddr_i` / `data_wdata_i` / `data_bvalid_o`).
- Queues dirty 256-bit lines so the DCache can refill without first waiting for the eviction to finish.
- Provides a combinational lookup so DCache read misses see the newest buffered copy of a line.

Parameters:
- DEPTH, 4, number of line entries; power of two, minimum 2.
- ADDR_W, 32, byte address width.
- LINE_W, 256, line width in bits (8 words, 32-byte line).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- push_i  in  1  DCache presents an evicted dirty line this cycle.
- push_addr_i  in  ADDR_W  line address; bits [4:0] are ignored and stored as zero.
- push_data_i  in  LINE_W  line data; word 0 is in [31:0].
- full_o  out  1  no free entry; a push in this cycle is refused.
- empty_o  out  1  no valid entry.
- count_o  out  log2(DEPTH)+1  number of valid entries.
- lookup_addr_i  in  ADDR_W  DCache read-miss address; compared on bits [31:5].
- hit_o  out  1  a valid entry matches `lookup_addr_i` (combinational).
- hit_data_o  out  LINE_W  data of the youngest matching entry; zero when no hit.
- axi_wen_o  out  1  drives the interface's `data_wen_i`.
- axi_awaddr_o  out  ADDR_W  head entry address; drives `data_awaddr_i`.
- axi_wdata_o  out  LINE_W  head entry data; drives `data_wdata_i`.
- axi_bvalid_i  in  1  one-cycle pulse from the interface (`data_bvalid_o`) after the 8-beat burst completes.

Behaviour:
- Storage: circular FIFO of DEPTH entries, each {valid, addr[31:5], data}. Registers: head pointer, tail pointer, count.
- Reset: all valid bits 0, pointers 0, count 0, drain FSM in IDLE.
  - Outputs under reset: full_o=0, empty_o=1, count_o=0, axi_wen_o=0, hit_o=0.
  - Reset asserted mid-burst discards all entries immediately. The downstream interface is reset by the same event.
- full_o = (count==DEPTH); empty_o = (count==0). Both derive from registered count only.
- Push acceptance: a push is accepted when push_i=1 and full_o=0.
  - The refused case includes a full buffer that is popping in the same cycle.
  - The DCache holds push_i until full_o=0.
  - An accepted push writes at the tail; the tail increments modulo DEPTH.
- Drain FSM states:
  - IDLE: if count>0, go to SEND next cycle.
  - SEND: axi_wen_o = !axi_bvalid_i. It is gated combinationally so the interface, which is FREE in the bvalid cycle, does not restart a burst with the old head. axi_awaddr_o and axi_wdata_o are held stable from the head entry for the whole burst. On axi_bvalid_i: pop the head (clear valid, head+1 mod DEPTH), go to IDLE.
  - IDLE to SEND takes one cycle, so there is at least one idle cycle between bursts.
- The head entry is in flight from SEND entry until its pop. No push may modify an in-flight entry.
- Simultaneous push and pop: count is unchanged. Pointers wrap independently.
- axi_bvalid_i outside SEND is ignored. It must not change count.
- Lookup:
  - Each valid entry compares addr[31:5] with lookup_addr_i[31:5].
  - On multiple matches (an in-flight head plus a newer entry), the entry youngest by distance from head wins.
  - A push to the same line in the same cycle is not visible to the lookup until the next cycle.
- axi_awaddr_o[4:0] = 0. axi_awaddr_o and axi_wdata_o show the head entry whenever count>0; they are don't-care when empty.

Optional Feature:
WB_MERGE_EN
- Defined: an accepted push whose line matches a valid entry that is not in flight overwrites that entry's data in place. Tail and count do not change. Such a push is accepted even when full_o=1.
  - A match only on the in-flight head appends normally.
  - Merging guarantees at most one non-in-flight entry per line.
- Undefined: every accepted push appends; the same line may occupy several entries.
- In both builds: lookup returns the youngest match, and the external port list is identical.

Test Plan:
- Reset, then single push addr=0x8000_0040, data word0=0x1111_1111 → next cycle count_o=1; SEND follows with axi_wen_o=1, axi_awaddr_o=0x8000_0040; bvalid pulse → axi_wen_o=0 in the same cycle, empty_o=1 next cycle.
- Push 4 distinct lines while bvalid is withheld → full_o=1; a 5th push of a new line is refused and count_o stays 4; drain order matches push order 0x100, 0x120, 0x140, 0x160.
- Full buffer with push and bvalid in the same cycle → push refused, count_o=3; push retried next cycle is accepted, count_o=4; pointers wrap correctly across 2 full fill/drain rounds.
- Head 0x200 in flight, push 0x200 with new data 0xAAAA… → appended (count 2); lookup 0x200 returns 0xAAAA…; axi_wdata_o keeps the old data until bvalid.
- WB_MERGE_EN: entries 0x300 (in flight) and 0x320 present, push 0x320 with 0x5555… → count stays 2 and lookup returns 0x5555…; without the macro, count becomes 3.
- Assert rst_n=0 mid-SEND → axi_wen_o=0, empty_o=1 immediately; after release the first push behaves as in the first scenario.
